// File: rtl/seq_restoring_divider.sv
// Unsigned WIDTH-bit restoring divider that produces one quotient bit per clock.
// Latency: done is high WIDTH+1 cycles after start is sampled, or 1 cycle for divide-by-zero.
// Backpressure: none. start is taken only in IDLE and ignored while busy or done; results hold.
module seq_restoring_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last_iter;
  logic             dvsr_zero;

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  assign dvsr_zero = (divisor == '0);

  // One restoring step: shift {R,Q} left, trial-subtract, keep or restore.
  // R is always below the divisor, so it fits in WIDTH bits. Only the shifted value needs the extra bit.
  always_comb begin
    r_sh  = {r, q[WIDTH-1]};
    trial = r_sh - {1'b0, dvsr};
    r_nxt = r_sh[WIDTH-1:0];
    q_nxt = {q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      r_nxt = trial[WIDTH-1:0];
      q_nxt = {q[WIDTH-2:0], 1'b1};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. A zero divisor goes straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = dvsr_zero ? DONE : RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are decoded from the state register, so they are registered signals.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operand capture, iteration datapath and held result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvsr        <= '0;
      r           <= '0;
      q           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvsr <= divisor;
            r    <= '0;
            q    <= dividend;
            cnt  <= '0;
            if (dvsr_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt + 1'b1;
          if (last_iter) begin
            quotient  <= q_nxt;
            remainder <= r_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider with a per-cycle arithmetic reference model.
// Latency: the model expects done WIDTH+1 cycles after the start sample, or 1 cycle for a zero divisor.
// Backpressure: the model drops start while an operation is running or done is up.
module tb_seq_restoring_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int vectors = 0;
  int miscompares = 0;

  seq_restoring_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Results come from / and %, and timing comes from a countdown.
  logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [31:0] m_q = '0, m_r = '0, pend_q = '0, pend_r = '0;
  int          m_left = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_q = '0; m_r = '0; m_left = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_q = pend_q; m_r = pend_r;
      end
    end else if (start) begin
      if (divisor == 0) begin
        m_done = 1'b1; m_q = 32'hFFFF_FFFF; m_r = dividend; m_dbz = 1'b1;
      end else begin
        m_busy = 1'b1; m_left = 32; m_dbz = 1'b0;
        pend_q = dividend / divisor;
        pend_r = dividend % divisor;
      end
    end
  end

  // Compare the DUT outputs with the model on every cycle.
  always @(negedge clk) begin
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
    chk("done", {31'b0, done}, {31'b0, m_done});
    chk("quotient", quotient, m_q);
    chk("remainder", remainder, m_r);
    chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_dbz});
  end

  // Run one operation and check its latency, busy time and results against literal values.
  // elat is the number of falling edges, counted from the start drive, until done is seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz,
                        input int elat, input int ebusy, input bit disturb);
    int  j = 0;
    int  bcnt = 0;
    bit  seen = 0;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    while (!seen && j < 100) begin
      @(negedge clk);
      j++;
      if (busy) bcnt++;
      if (done) seen = 1;
      if (j == 1) start = 1'b0;
      if (disturb && j == 10) begin start = 1'b1; dividend = 32'd9; divisor = 32'd3; end
      if (disturb && j == 11) begin start = 1'b0; dividend = 32'hDEAD; divisor = 32'd1; end
    end
    chk("done_seen", {31'b0, seen}, 32'd1);
    chk("latency", j, elat);
    chk("busy_cycles", bcnt, ebusy);
    chk("lit_quotient", quotient, eq);
    chk("lit_remainder", remainder, er);
    chk("lit_dbz", {31'b0, div_by_zero}, {31'b0, edz});
    chk("model_quotient", m_q, eq);
    chk("model_remainder", m_r, er);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    int dcnt;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 32, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33, 32, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 32, 0);
    run_op(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33, 32, 0);
    run_op(32'h8000_0000, 32'h8000_0001, 32'd0, 32'h8000_0000, 1'b0, 33, 32, 0);
    run_op(32'hDEAD_BEEF, 32'd16, 32'h0DEA_DBEE, 32'hF, 1'b0, 33, 32, 0);
    run_op(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33, 32, 0);
    run_op(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0, 0);
    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 32, 0);
    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 32, 1);

    // Abandon an operation with a reset in the middle of RUN.
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_dbz", {31'b0, div_by_zero}, 32'd0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("midrst_no_done", dcnt, 32'd0);

    run_op(32'd50, 32'd6, 32'd8, 32'd2, 1'b0, 33, 32, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
